shift_add_mult: RTL and testbench



---
 rtl/mult_pkg.sv | 17 +
 rtl/mult_dp.sv | 46 ++++
 rtl/shift_add_mult.sv | 89 ++++++++
 tb/tb_shift_add_mult.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
// Also used by the optional MULT_FUSED_EN build of shift_add_mult.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } mult_state_t;

  // Bit counter must hold 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 3) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mult_dp.sv
// Datapath of the shift-and-add multiplier: R = {carry, acc, mul} and latched multiplicand M.
// add and shift may be asserted together; the add result is then shifted in the same cycle.
module mult_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               load,
  input  logic               add,
  input  logic               shift,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               lsb,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH:0] r;
  logic [2*WIDTH:0] r_sum;
  logic [2*WIDTH:0] r_next;
  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum    = {1'b0, r[2*WIDTH-1:WIDTH]} + {1'b0, m};
    r_sum  = (add && r[0]) ? {sum, r[WIDTH-1:0]} : r;
    r_next = shift ? (r_sum >> 1) : r_sum;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r <= '0;
      m <= '0;
    end else if (load) begin
      r <= {1'b0, {WIDTH{1'b0}}, multiplier};
      m <= multiplicand;
    end else begin
      r <= r_next;
    end
  end

  assign lsb     = r[0];
  assign product = r[2*WIDTH-1:0];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier with start/busy/done handshake.
// Define MULT_FUSED_EN to merge ADD and SHIFT into one state (WIDTH cycles per multiply).
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  mult_state_t   state;
  logic [CW-1:0] cnt;
  logic          load;
  logic          add;
  logic          shift;
  logic          lsb;

  always_comb begin
    load  = (state == IDLE) && start;
`ifdef MULT_FUSED_EN
    add   = (state == ADD);
    shift = (state == ADD);
`else
    add   = (state == ADD);
    shift = (state == SHIFT);
`endif
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt   <= '0;
          state <= ADD;
        end
`ifdef MULT_FUSED_EN
        ADD: begin
          if (cnt == LAST) state <= DONE;
          else cnt <= cnt + 1'b1;
        end
`else
        ADD: state <= SHIFT;
        SHIFT: begin
          if (cnt == LAST) state <= DONE;
          else begin
            cnt   <= cnt + 1'b1;
            state <= ADD;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  mult_dp #(.WIDTH(WIDTH)) u_dp (
    .clk          (clk),
    .n_reset      (n_reset),
    .load         (load),
    .add          (add),
    .shift        (shift),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .lsb          (lsb),
    .product      (product)
  );

  // lsb is exported for observability; the FSM does not need it.
  logic unused_lsb;
  assign unused_lsb = lsb;

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult at WIDTH=4 and WIDTH=8 (honours MULT_FUSED_EN).
module tb_shift_add_mult;

`ifdef MULT_FUSED_EN
  localparam int LAT4 = 4;
  localparam int LAT8 = 8;
`else
  localparam int LAT4 = 8;
  localparam int LAT8 = 16;
`endif

  typedef struct {
    logic [15:0] p;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        start4 = 1'b0, start8 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  p4;
  logic [15:0] p8;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q4[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_add_mult #(.WIDTH(4)) u4 (
    .clk(clk), .n_reset(n_reset), .start(start4), .multiplicand(a4),
    .multiplier(b4), .busy(busy4), .done(done4), .product(p4));

  shift_add_mult #(.WIDTH(8)) u8 (
    .clk(clk), .n_reset(n_reset), .start(start8), .multiplicand(a8),
    .multiplier(b8), .busy(busy8), .done(done8), .product(p8));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitors: pop on every done pulse, compare value and arrival cycle.
  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) check("w4_unexpected_done", 32'(p4), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = q4.pop_front();
        check("w4_product", 32'(p4), 32'(e.p));
        check("w4_done_cycle", 32'(cyc), 32'(e.c));
      end
    end
    if (done8) begin
      if (q8.size() == 0) check("w8_unexpected_done", 32'(p8), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = q8.pop_front();
        check("w8_product", 32'(p8), 32'(e.p));
        check("w8_done_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  // Called at a negedge with the chosen DUT idle; returns #1 after the accepting edge.
  task automatic issue(input bit w8, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] prod, output int k);
    exp_t e;
    if (w8) begin start8 = 1'b1; a8 = a; b8 = b; end
    else    begin start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; end
    @(posedge clk);
    #1;
    k = cyc;
    e.p = prod;
    e.c = k + (w8 ? LAT8 : LAT4);
    if (w8) begin q8.push_back(e); start8 = 1'b0; check("w8_busy_rise", 32'(busy8), 1); end
    else    begin q4.push_back(e); start4 = 1'b0; check("w4_busy_rise", 32'(busy4), 1); end
    // Later operand changes must be ignored.
    a4 = 4'hF; b4 = 4'hF; a8 = 8'hAA; b8 = 8'h55;
  endtask

  task automatic wait_idle(input bit w8);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((w8 ? busy8 : busy4) && n < 200);
    if (n >= 200) check(w8 ? "w8_idle_timeout" : "w4_idle_timeout", 1, 0);
  endtask

  task automatic run(input bit w8, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] prod);
    int k;
    issue(w8, a, b, prod, k);
    wait_idle(w8);
  endtask

  initial begin
    int k, kprev, n;
    logic [7:0]  ta [3];
    logic [7:0]  tb [3];
    logic [15:0] tp [3];

    // Reset with nonzero operands on the pins.
    a4 = 4'd9; b4 = 4'd8; a8 = 8'd77; b8 = 8'd3;
    #1;
    check("rst_product4", 32'(p4), 0);
    check("rst_busy4", 32'(busy4), 0);
    check("rst_done4", 32'(done4), 0);
    check("rst_product8", 32'(p8), 0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_busy4", 32'(busy4), 0);
    check("idle_product4", 32'(p4), 0);

    // Basic multiply, result held after completion.
    run(1'b0, 8'd9, 8'd8, 16'd72);
    repeat (3) @(negedge clk);
    check("w4_hold_72", 32'(p4), 72);
    check("w4_done_low", 32'(done4), 0);

    run(1'b0, 8'd15, 8'd15, 16'd225);
    run(1'b0, 8'd0, 8'd13, 16'd0);
    run(1'b0, 8'd13, 8'd0, 16'd0);

    // Start while busy is ignored.
    issue(1'b0, 8'd9, 8'd8, 16'd72, k);
    repeat (3) @(negedge clk);
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
    @(negedge clk);
    start4 = 1'b0;
    wait_idle(1'b0);

    // Start pulsed during the DONE cycle is lost.
    issue(1'b0, 8'd7, 8'd5, 16'd35, k);
    n = 0;
    do begin @(negedge clk); n++; end while (!done4 && n < 200);
    if (n >= 200) check("w4_done_timeout", 1, 0);
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
    @(negedge clk);
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    check("w4_start_in_done_ignored", 32'(busy4), 0);
    check("w4_hold_35", 32'(p4), 35);

    // Reset mid-multiply aborts with no done pulse.
    issue(1'b0, 8'd9, 8'd8, 16'd72, k);
    repeat (3) @(negedge clk);
    n_reset = 1'b0;
    #1;
    check("midrst_product4", 32'(p4), 0);
    check("midrst_busy4", 32'(busy4), 0);
    check("midrst_done4", 32'(done4), 0);
    q4.delete();
    @(negedge clk);
    n_reset = 1'b1;
    repeat (LAT4 + 4) @(negedge clk);
    check("midrst_no_restart", 32'(busy4), 0);
    run(1'b0, 8'd5, 8'd6, 16'd30);

    // WIDTH=8 corner cases.
    run(1'b1, 8'd255, 8'd255, 16'd65025);
    run(1'b1, 8'd128, 8'd2, 16'd256);

    // Back-to-back with start held high.
    ta = '{8'd100, 8'd37, 8'd1};
    tb = '{8'd100, 8'd11, 8'd255};
    tp = '{16'd10000, 16'd407, 16'd255};
    kprev = 0;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      start8 = 1'b1; a8 = ta[i]; b8 = tb[i];
      @(posedge clk);
      #1;
      k = cyc;
      e.p = tp[i];
      e.c = k + LAT8;
      q8.push_back(e);
      if (i > 0) check("w8_b2b_interval", 32'(k - kprev), 32'(LAT8 + 2));
      kprev = k;
      wait_idle(1'b1);
    end
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("w8_b2b_stopped", 32'(busy8), 0);
    check("w8_hold_255", 32'(p8), 255);

    check("w4_queue_drained", 32'(q4.size()), 0);
    check("w8_queue_drained", 32'(q8.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
